// File: rtl/musa_pkg.sv
// rtl/musa_pkg.sv - shared MUSA datapath types and defaults
package musa_pkg;

  // Redirect select driven by the control block.
  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_RET    = 2'b11
  } pc_src_t;

  // FETCH issues requests; DISCARD waits out a request made stale by a redirect.
  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } fetch_state_t;

  localparam int unsigned DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/musa_fetch_queue.sv
// rtl/musa_fetch_queue.sv - small synchronous FIFO holding fetched {instruction, pc}
module musa_fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only observed while the queue is non-empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/musa_fetch_stage.sv
// rtl/musa_fetch_stage.sv - MUSA instruction fetch stage with redirect and discard handling
module musa_fetch_stage #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter int          QDEPTH     = 2,
  parameter int unsigned RESET_PC   = musa_pkg::DEFAULT_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            pc_src,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic [ADDR_WIDTH-1:0] ret_addr,
  input  logic                  stall,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_instruction,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [ADDR_WIDTH-1:0] if_pc_plus1
);

  import musa_pkg::*;

  localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH;
  localparam int CNT_W   = $clog2(QDEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] discard_addr;
  logic [ADDR_WIDTH-1:0] target;
  logic                  redirect;
  logic                  accept;
  logic                  q_push;
  logic                  q_pop;
  logic [ENTRY_W-1:0]    q_head;
  logic [CNT_W-1:0]      q_count;
  logic                  q_empty;
  logic                  q_full;
  logic [DATA_WIDTH-1:0] head_instr;
  logic [ADDR_WIDTH-1:0] head_pc;

  assign redirect = (pc_src != PC_SEQ);

  // Select the redirect target for the current pc_src.
  always_comb begin
    target = pc;
    case (pc_src)
      PC_BRANCH: target = branch_target;
      PC_JUMP:   target = jump_target;
      PC_RET:    target = ret_addr;
      default:   target = pc;
    endcase
  end

  // A stale request in DISCARD must be completed even though the queue was flushed.
  assign imem_req  = !rst && ((state == DISCARD) || !q_full);
  assign imem_addr = (state == DISCARD) ? discard_addr : pc;
  assign accept    = imem_req && imem_ack;

  assign q_push = (state == FETCH) && accept && !redirect;
  assign q_pop  = if_valid && !stall && !redirect;

  // PC and fetch state machine; redirect outranks acks, stall and sequential advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FETCH;
      pc           <= ADDR_WIDTH'(RESET_PC);
      discard_addr <= '0;
    end else if (redirect) begin
      pc <= target;
      if (state == FETCH) begin
        if (imem_req && !imem_ack) begin
          state        <= DISCARD;
          discard_addr <= pc;
        end
      end else if (imem_ack) begin
        state <= FETCH;
      end
    end else if (state == DISCARD) begin
      if (imem_ack) state <= FETCH;
    end else if (accept) begin
      pc <= pc + PC_ONE;
    end
  end

  musa_fetch_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect),
    .wdata ({imem_rdata, pc}),
    .rdata (q_head),
    .count (q_count),
    .empty (q_empty),
    .full  (q_full)
  );

  assign head_instr = q_head[ENTRY_W-1:ADDR_WIDTH];
  assign head_pc    = q_head[ADDR_WIDTH-1:0];

  // Head fields read as zero whenever nothing valid is presented.
  assign if_valid       = !q_empty;
  assign if_instruction = q_empty ? '0 : head_instr;
  assign if_pc          = q_empty ? '0 : head_pc;
  assign if_pc_plus1    = q_empty ? '0 : head_pc + PC_ONE;

  // Occupancy never exceeds the configured depth.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    q_count <= CNT_W'(QDEPTH));

endmodule

// File: tb/tb_musa_fetch_stage.sv
// tb/tb_musa_fetch_stage.sv - self-checking bench for musa_fetch_stage
module tb_musa_fetch_stage;

  localparam int QDEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pc_src = 2'b00;
  logic [31:0] branch_target = '0;
  logic [31:0] jump_target = '0;
  logic [31:0] ret_addr = '0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int mem_wait = 0;
  int wait_cnt;
  logic mem_ready;

  musa_fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .pc_src         (pc_src),
    .branch_target  (branch_target),
    .jump_target    (jump_target),
    .ret_addr       (ret_addr),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .if_pc_plus1    (if_pc_plus1)
  );

  always #5 clk = ~clk;

  // Instruction memory: word at addr is 0x1000_0000+addr, ack after mem_wait wait states.
  assign mem_ready  = (wait_cnt >= mem_wait);
  assign imem_ack   = imem_req && mem_ready;
  assign imem_rdata = 32'h1000_0000 + imem_addr;

  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list of pcs owed to decode, next fetch pc, and a pending-stale-request flag.
  logic [31:0] mq[$];
  logic [31:0] m_pc = '0;
  logic [31:0] m_old = '0;
  bit          m_disc = 1'b0;

  initial begin
    logic        m_req;
    logic        m_ack;
    logic [31:0] m_tgt;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        m_pc   = '0;
        m_old  = '0;
        m_disc = 1'b0;
      end else begin
        m_req = m_disc || (mq.size() < QDEPTH);
        m_ack = m_req && mem_ready;
        if (pc_src != 2'b00) begin
          m_tgt = (pc_src == 2'b01) ? branch_target :
                  (pc_src == 2'b10) ? jump_target : ret_addr;
          mq.delete();
          if (m_disc) begin
            if (m_ack) m_disc = 1'b0;
          end else if (m_req && !m_ack) begin
            m_disc = 1'b1;
            m_old  = m_pc;
          end
          m_pc = m_tgt;
        end else begin
          if (mq.size() != 0 && !stall) void'(mq.pop_front());
          if (m_ack) begin
            if (m_disc) m_disc = 1'b0;
            else begin
              mq.push_back(m_pc);
              m_pc = m_pc + 32'd1;
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && chk_en) begin
        chk("m_if_valid", {63'd0, if_valid}, {63'd0, mq.size() != 0});
        if (mq.size() != 0) begin
          chk("m_if_pc", {32'd0, if_pc}, {32'd0, mq[0]});
          chk("m_if_instruction", {32'd0, if_instruction}, {32'd0, 32'h1000_0000 + mq[0]});
          chk("m_if_pc_plus1", {32'd0, if_pc_plus1}, {32'd0, mq[0] + 32'd1});
        end
        chk("m_imem_req", {63'd0, imem_req}, {63'd0, m_disc || (mq.size() < QDEPTH)});
        if (imem_req)
          chk("m_imem_addr", {32'd0, imem_addr}, {32'd0, m_disc ? m_old : m_pc});
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int n;

    // Reset state
    tick();
    tick();
    chk("rst_imem_req", {63'd0, imem_req}, 64'd0);
    chk("rst_if_valid", {63'd0, if_valid}, 64'd0);
    chk("rst_if_pc", {32'd0, if_pc}, 64'd0);
    chk("rst_if_instruction", {32'd0, if_instruction}, 64'd0);
    chk("rst_if_pc_plus1", {32'd0, if_pc_plus1}, 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rel_imem_req", {63'd0, imem_req}, 64'd1);
    chk("rel_imem_addr", {32'd0, imem_addr}, 64'd0);

    // Zero-wait sequential fetch: pc 0..3 on consecutive cycles
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("seq_if_valid", {63'd0, if_valid}, 64'd1);
      chk("seq_if_pc", {32'd0, if_pc}, 64'(i));
      chk("seq_if_instruction", {32'd0, if_instruction}, 64'(32'h1000_0000 + i));
      chk("seq_if_pc_plus1", {32'd0, if_pc_plus1}, 64'(i + 1));
    end

    // Asynchronous reset mid-cycle, then stall back-pressure from a clean start
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_imem_req", {63'd0, imem_req}, 64'd0);
    chk("async_rst_if_valid", {63'd0, if_valid}, 64'd0);
    stall = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("stall_if_pc", {32'd0, if_pc}, 64'd0);
      chk("stall_if_valid", {63'd0, if_valid}, 64'd1);
      if (k >= 2) chk("stall_full_no_req", {63'd0, imem_req}, 64'd0);
    end
    stall = 1'b0;
    tick();
    chk("unstall_pc1", {32'd0, if_pc}, 64'd1);
    tick();
    chk("unstall_pc2", {32'd0, if_pc}, 64'd2);

    // Branch coincident with the ack of addr 7
    n = 0;
    while (imem_addr != 32'd7 && n < 60) begin
      tick();
      n++;
    end
    chk("reach_addr7", {32'd0, imem_addr}, 64'd7);
    chk("addr7_acked_now", {63'd0, imem_ack}, 64'd1);
    pc_src = 2'b01;
    branch_target = 32'h80;
    tick();
    pc_src = 2'b00;
    chk("br_imem_addr", {32'd0, imem_addr}, 64'h80);
    chk("br_if_valid_flushed", {63'd0, if_valid}, 64'd0);
    tick();
    chk("br_first_if_pc", {32'd0, if_pc}, 64'h80);

    // Slow memory, redirect to 3, then a jump to 0x40 while addr 5 is in flight
    mem_wait = 3;
    pc_src = 2'b01;
    branch_target = 32'h3;
    tick();
    pc_src = 2'b00;
    n = 0;
    while (!(imem_addr == 32'd5 && imem_req) && n < 80) begin
      tick();
      n++;
    end
    chk("reach_addr5", {32'd0, imem_addr}, 64'd5);
    tick();
    pc_src = 2'b10;
    jump_target = 32'h40;
    tick();
    pc_src = 2'b00;
    chk("disc_addr_held_a", {32'd0, imem_addr}, 64'd5);
    chk("disc_req_held", {63'd0, imem_req}, 64'd1);
    chk("disc_if_valid", {63'd0, if_valid}, 64'd0);
    tick();
    chk("disc_addr_held_b", {32'd0, imem_addr}, 64'd5);
    tick();
    chk("jmp_next_addr", {32'd0, imem_addr}, 64'h40);
    chk("jmp_dropped", {63'd0, if_valid}, 64'd0);
    n = 0;
    while (!if_valid && n < 20) begin
      tick();
      n++;
    end
    chk("jmp_first_if_pc", {32'd0, if_pc}, 64'h40);

    // Return to all-ones address and wrap
    mem_wait = 0;
    pc_src = 2'b11;
    ret_addr = 32'hFFFF_FFFF;
    tick();
    pc_src = 2'b00;
    chk("ret_imem_addr", {32'd0, imem_addr}, 64'hFFFF_FFFF);
    tick();
    chk("wrap_if_pc", {32'd0, if_pc}, 64'hFFFF_FFFF);
    chk("wrap_if_pc_plus1", {32'd0, if_pc_plus1}, 64'd0);
    chk("wrap_if_instruction", {32'd0, if_instruction}, 64'h0FFF_FFFF);
    chk("wrap_next_addr", {32'd0, imem_addr}, 64'd0);
    tick();
    chk("wrap_then_pc0", {32'd0, if_pc}, 64'd0);

    repeat (4) tick();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/musa_fetch_stage.md
Name: musa_fetch_stage

Overview:
- Instruction-fetch stage of the MUSA datapath, directly upstream of the decode/control block.
- Holds the PC and issues single-outstanding word reads to instruction memory.
- Buffers returned words in a small queue and presents {instruction, pc, pc+1} to decode with a valid/stall handshake.
- Applies pc_src redirects (branch/jump/return) from control, including flushing and discarding in-flight fetches.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, PC / instruction-address width; the PC is word-addressed.
- QDEPTH, 2, instruction queue entries; power of two, ≥1.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- pc_src  in  2  redirect select: 00 sequential, 01 branch, 10 jump, 11 return; sampled every cycle.
- branch_target  in  ADDR_WIDTH  target used when pc_src=01.
- jump_target  in  ADDR_WIDTH  target used when pc_src=10.
- ret_addr  in  ADDR_WIDTH  target used when pc_src=11 (from stack pop).
- stall  in  1  decode cannot accept this cycle.
- imem_req  out  1  read request; held high until acknowledged.
- imem_addr  out  ADDR_WIDTH  read address; stable while imem_req is high.
- imem_ack  in  1  read complete; imem_rdata valid in the same cycle.
- imem_rdata  in  DATA_WIDTH  instruction word.
- if_valid  out  1  queue head is valid.
- if_instruction  out  DATA_WIDTH  queue-head instruction.
- if_pc  out  ADDR_WIDTH  address of the queue-head instruction.
- if_pc_plus1  out  ADDR_WIDTH  if_pc+1, modulo 2^ADDR_WIDTH.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - pc=RESET_PC; queue empty; state=FETCH.
  - imem_req=0; if_valid=0; if_instruction=0; if_pc=0; if_pc_plus1=0.
- Reset mid-transaction: state is cleared immediately; the outstanding request is abandoned and any ack in the reset cycle is ignored.
- State machine:
  - FETCH: imem_req=1 and imem_addr=pc whenever count<QDEPTH.
    - On imem_ack with no redirect: push {rdata, pc}; pc<=pc+1.
    - Stay in FETCH.
  - DISCARD: entered when a redirect occurs while imem_req=1 and imem_ack=0.
    - imem_req stays 1 and imem_addr keeps the old address.
    - On imem_ack, the data is dropped and state goes to FETCH.
    - pc already holds the redirect target.
- imem_req/imem_addr are combinational from state, count and pc. A zero-wait memory (ack in the same cycle as req) therefore sustains 1 instruction/cycle.
- Latency: a word acked in cycle N appears on if_valid in cycle N+1 (registered queue).
- Handshake to decode:
  - Pop occurs when if_valid && !stall.
  - Head outputs hold steady while stall=1.
  - Push and pop in the same cycle leave count unchanged.
  - No request is issued when count==QDEPTH, so queue overflow is impossible.
- Redirect (pc_src != 00) has priority over everything except reset:
  - The queue is flushed: if_valid=0 next cycle.
  - pc<=selected target.
  - Any ack in the same cycle is dropped and the state stays FETCH.
  - Redirect overrides stall.
  - A redirect arriving during DISCARD updates pc again and remains in DISCARD.
- Arithmetic: pc+1 wraps modulo 2^ADDR_WIDTH (all-ones → 0).

Decomposition:
- Shared package musa_pkg holds:
  - pc_src_t enum (PC_SEQ, PC_BRANCH, PC_JUMP, PC_RET), also consumed by the control block.
  - fetch_state_t (FETCH, DISCARD).
  - RESET_PC default.
- One sub-module, musa_fetch_queue: parameterised synchronous FIFO (DATA_WIDTH+ADDR_WIDTH wide, QDEPTH deep) with push, pop, flush, count, empty and full.

Test Plan:
- Reset: rst pulsed asynchronously mid-cycle → imem_req=0 and if_valid=0 immediately; after release, imem_addr=0x0 with imem_req=1.
- Zero-wait sequential fetch: memory returns 0x1000_0000+addr with ack same-cycle, stall=0 → if_pc 0,1,2,3 on consecutive cycles; if_instruction 0x1000_0000..0x1000_0003; if_pc_plus1 = if_pc+1.
- Stall back-pressure, QDEPTH=2: stall held 5 cycles → exactly 2 words queued, imem_req=0 while full; the head stays at pc 0 during stall; release yields pc 0,1,2 with none lost or duplicated.
- Redirect with a 3-wait-state memory: pc_src=10, jump_target=0x40 one cycle after the request to addr 5 → imem_addr remains 5 until ack; that data is discarded; next request is addr 0x40; first if_pc=0x40.
- Redirect coincident with ack: pc_src=01, branch_target=0x80 in the same cycle as ack for addr 7 → the addr-7 word never appears on if_valid; next imem_addr=0x80; no DISCARD state.
- Wrap and return: ret_addr=all-ones via pc_src=11 → if_pc=0xFFFF_FFFF, if_pc_plus1=0, next fetch addr=0.
